approx_mult_pipe: RTL and testbench
===================================

Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 approximate unsigned multipliers.
- Drops every partial-product bit in columns below a run-time truncation level K; all higher columns are summed exactly.
- Two register stages with valid/ready backpressure, so it can sit directly in accelerator datapaths.
- Includes a completed-operation counter for error/throughput characterisation.

Parameters:
- WIDTH, 8, operand width in bits; both operands unsigned.
- KW, 4, width of the truncation-level input; must satisfy 2^KW >= 2*WIDTH.
- MAX_K, 8, upper clamp for the effective truncation level; must be <= 2*WIDTH-1.
- CNT_W, 16, width of the operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- x  in  WIDTH  multiplicand, unsigned.
- y  in  WIDTH  multiplier, unsigned.
- trunc_k  in  KW  requested truncation level K, sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- z  out  2*WIDTH  approximate product.
- z_k  out  KW  effective K used for this z, after clamping.
- op_count  out  CNT_W  number of results accepted downstream.

Behaviour:
- Interface: one clock (clk), asynchronous active-high reset (rst).
- Reset values: in_ready=1 after reset release; out_valid=0, z=0, z_k=0, op_count=0. All pipeline valid bits clear.
- Clamping: Keff = min(trunc_k, MAX_K), computed in stage 0 and carried with the data.
- Partial-product bit x[i]&y[j] sits in column c=i+j.
- Keep the bit iff c >= Keff; a kept bit contributes 2^c to z. Dropped bits contribute nothing.
- Keff=0 gives the exact product.
- z is full 2*WIDTH width; no overflow is possible because approx <= exact.
- Stage 1 (S1): register two row-group sums.
  - Lower rows: i < WIDTH/2.
  - Upper rows: i >= WIDTH/2.
  - Register Keff alongside.
- Stage 2 (S2): register the sum of the two groups, plus the compensation term if enabled, into z/z_k.
- Latency: 2 cycles from an in_valid&&in_ready edge to out_valid, when no stall occurs.
- Throughput: 1 beat/cycle.
- Handshake:
  - A stage advances when its successor is empty or being drained.
  - in_ready = !s1_valid || s2_can_accept.
  - s2_can_accept = !out_valid || out_ready.
  - Data, z and z_k hold stable while out_valid && !out_ready.
  - No combinational path from in_valid to in_ready.
- Full pipeline with out_ready=0: in_ready=0 after two accepted beats. No beat is lost or duplicated. Order is preserved.
- Simultaneous drain and fill: when out_ready=1 and out_valid=1, a new beat is accepted in the same cycle.
- op_count increments on each out_valid&&out_ready edge and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all in-flight beats are discarded. Outputs return to reset values asynchronously.
- trunc_k may change every beat; each result uses its own sampled K.

Optional Feature:
- Macro: APPROX_COMP_EN.
- Defined: S2 adds a rounding compensation of 2^(Keff-1) when Keff >= 1, and 0 when Keff = 0.
  - The sum saturates at 2^(2*WIDTH)-1.
  - z_k is unchanged.
- Undefined: no compensation term and no saturation logic. z is the pure truncated sum.

Test Plan:
- WIDTH=8, x=255, y=255, K=0 -> z=65025 after 2 cycles, z_k=0.
- x=255, y=255, K=8 -> z=63232 (1793 dropped). With APPROX_COMP_EN -> z=63360.
- x=3, y=5, K=2 -> z=12 (columns 0,1 drop 3). With APPROX_COMP_EN -> z=14.
- trunc_k=15 with MAX_K=8 -> z_k=8, and z matches the K=8 result for the same operands.
- Backpressure: out_ready=0 while driving 3 back-to-back beats.
  - in_ready drops after beat 2 is accepted.
  - Raising out_ready yields the results in order, with one result per cycle.
  - op_count=3.
- Reset assert mid-stream with 2 beats in flight -> out_valid=0, z=0, op_count=0 immediately; no stale result after release.
- 65536 accepted results with CNT_W=16 -> op_count wraps to 0.

Source files
------------

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: two-stage valid/ready truncated unsigned multiplier with a run-time truncation level and an op counter.
// Define APPROX_COMP_EN to add a saturating 2^(Keff-1) rounding compensation in the output stage.
module approx_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int KW    = 4,
  parameter int MAX_K = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [KW-1:0]        trunc_k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
  output logic [KW-1:0]        z_k,
  output logic [CNT_W-1:0]     op_count
);
  localparam int PW = 2 * WIDTH;
  localparam int HW = WIDTH / 2;
  logic             s1_valid_q, s1_valid_d;
  logic [PW-1:0]    s1_lo_q, s1_lo_d, s1_hi_q, s1_hi_d;
  logic [KW-1:0]    s1_k_q, s1_k_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    z_q, z_d;
  logic [KW-1:0]    z_k_q, z_k_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [KW-1:0]    keff;
  logic [PW-1:0]    keep_mask, row, lo_sum, hi_sum, s2_sum;
  logic             s2_can_accept, in_fire, s2_load;
`ifdef APPROX_COMP_EN
  logic [PW-1:0]    comp;
  logic [PW:0]      sum_w;
`endif
  // Each shifted row lines bit j up with column i+j, so one mask drops every column below Keff.
  always_comb begin
    keff = (trunc_k > KW'(MAX_K)) ? KW'(MAX_K) : trunc_k;
    keep_mask = {PW{1'b1}} << keff;
    row = '0;
    lo_sum = '0;
    hi_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = (({PW{x[i]}} & PW'(y)) << i) & keep_mask;
      if (i < HW) lo_sum = lo_sum + row;
      else hi_sum = hi_sum + row;
    end
  end
  always_comb begin
`ifdef APPROX_COMP_EN
    comp = (s1_k_q == '0) ? '0 : (PW'(1) << (s1_k_q - 1'b1));
    sum_w = {1'b0, s1_lo_q} + {1'b0, s1_hi_q} + {1'b0, comp};
    s2_sum = sum_w[PW] ? {PW{1'b1}} : sum_w[PW-1:0];
`else
    s2_sum = s1_lo_q + s1_hi_q;
`endif
  end
  always_comb begin
    s2_can_accept = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_can_accept;
    in_fire = in_valid && in_ready;
    s2_load = s1_valid_q && s2_can_accept;
    s1_valid_d = in_fire || (s1_valid_q && !s2_can_accept);
    s1_lo_d = in_fire ? lo_sum : s1_lo_q;
    s1_hi_d = in_fire ? hi_sum : s1_hi_q;
    s1_k_d = in_fire ? keff : s1_k_q;
    out_valid_d = s2_can_accept ? s1_valid_q : out_valid_q;
    z_d = s2_load ? s2_sum : z_q;
    z_k_d = s2_load ? s1_k_q : z_k_q;
    op_count_d = op_count_q + CNT_W'(out_valid_q && out_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q <= '0;
      s1_hi_q <= '0;
      s1_k_q <= '0;
      out_valid_q <= 1'b0;
      z_q <= '0;
      z_k_q <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q <= s1_lo_d;
      s1_hi_q <= s1_hi_d;
      s1_k_q <= s1_k_d;
      out_valid_q <= out_valid_d;
      z_q <= z_d;
      z_k_q <= z_k_d;
      op_count_q <= op_count_d;
    end
  end
  assign out_valid = out_valid_q;
  assign z = z_q;
  assign z_k = z_k_q;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: directed and random checks of approx_mult_pipe against a column-rule reference model and FIFO scoreboard.
module tb_approx_mult_pipe;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0]  x = '0, y = '0;
  logic [3:0]  trunc_k = '0, z_k;
  logic [15:0] z, op_count;
  int          n_vec = 0, n_err = 0;
  logic [15:0] qz[$];
  int          qk[$];
  logic [15:0] cnt_m = '0;

  approx_mult_pipe dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .trunc_k(trunc_k), .out_valid(out_valid), .out_ready(out_ready), .z(z), .z_k(z_k), .op_count(op_count));

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input int k);
    int ke = (k > 8) ? 8 : k;
    longint s = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j] && (i + j) >= ke) s += longint'(1) << (i + j);
`ifdef APPROX_COMP_EN
    if (ke > 0) s += longint'(1) << (ke - 1);
    if (s > 65535) s = 65535;
`endif
    return s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive, check outputs against the scoreboard, then advance one cycle.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] k, input logic r);
    in_valid = v; x = a; y = b; trunc_k = k; out_ready = r;
    #1;
    chk("op_count", op_count, cnt_m);
    if (qz.size() == 0) chk("idle_valid", out_valid, 0);
    else if (out_valid) begin
      chk("z", z, qz[0]);
      chk("z_k", z_k, qk[0]);
      if (r) begin
        void'(qz.pop_front());
        void'(qk.pop_front());
        cnt_m++;
      end
    end
    if (v && in_ready) begin
      qz.push_back(model(a, b, k));
      qk.push_back((k > 8) ? 8 : k);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k, input logic [15:0] ez, input logic [3:0] ek);
    step(1, a, b, k, 1);
    #1 chk("lat1_valid", out_valid, 0);
    step(0, 0, 0, 0, 1);
    #1 chk("lat2_valid", out_valid, 1);
    chk("lit_z", z, ez);
    chk("lit_zk", z_k, ek);
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_zk", z_k, 0);
    chk("rst_cnt", op_count, 0);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    one(8'd255, 8'd255, 4'd0, 16'd65025, 4'd0);
`ifdef APPROX_COMP_EN
    one(8'd255, 8'd255, 4'd8, 16'd63360, 4'd8);
    one(8'd3, 8'd5, 4'd2, 16'd14, 4'd2);
    one(8'd255, 8'd255, 4'd15, 16'd63360, 4'd8);
`else
    one(8'd255, 8'd255, 4'd8, 16'd63232, 4'd8);
    one(8'd3, 8'd5, 4'd2, 16'd12, 4'd2);
    one(8'd255, 8'd255, 4'd15, 16'd63232, 4'd8);
`endif
    // Two beats in flight, then an asynchronous reset between clock edges.
    step(1, 8'd17, 8'd99, 4'd3, 0);
    step(1, 8'd200, 8'd7, 4'd1, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_z", z, 0);
    chk("arst_zk", z_k, 0);
    chk("arst_cnt", op_count, 0);
    qz.delete();
    qk.delete();
    cnt_m = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    // Backpressure: third beat must stall until the output drains.
    step(1, 8'd10, 8'd20, 4'd0, 0);
    step(1, 8'd33, 8'd44, 4'd5, 0);
    #1 chk("bp_in_ready", in_ready, 0);
    step(1, 8'd250, 8'd129, 4'd9, 0);
    step(1, 8'd250, 8'd129, 4'd9, 0);
    step(1, 8'd250, 8'd129, 4'd9, 1);
    #1 chk("bp_drain2", out_valid, 1);
    step(0, 0, 0, 0, 1);
    #1 chk("bp_drain3", out_valid, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("bp_count", op_count, 3);
    chk("bp_empty", qz.size(), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("rand_empty", qz.size(), 0);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_m = '0;
    for (int i = 0; i < 65536; i++) step(1, 8'($urandom), 8'($urandom), 4'($urandom), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_count", op_count, 0);
    chk("wrap_empty", qz.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
